mult_25x18_mreg: RTL
====================

Name: mult_25x18_mreg

Overview:
- Multiplier stage directly downstream of the dual A/D pre-adder.
- Consumes the 25-bit A_mult operand (pre-adder output or gated A) and the 18-bit B operand from the B register stage.
- Produces two 43-bit partial products and a product-sign flag, with an optional M pipeline register.
- The ALU stage sums the two partials through its X/Y muxes. The sign flag feeds the rounding carry-in select.

Parameters:
- sel_M_p, default 1: M register enable. 1 = partials and sign registered (MREG=1). 0 = combinational pass (MREG=0).
- use_mult_p, default "MULTIPLY": "MULTIPLY" = normal operation. "NONE" = multiplier disabled, all outputs forced to 0.

Ports:
- clk  input  1  single clock, rising edge
- RSTM  input  1  asynchronous, active-high reset of the M register
- CEM  input  1  M register clock enable
- A_mult  input  25  signed two's-complement multiplicand (from pre-adder out3)
- B_mult  input  18  signed two's-complement multiplier
- M1  output  43  partial product, low part
- M2  output  43  partial product, high part, pre-shifted
- mult_sign  output  1  sign of the full product

Behaviour:
- Interface:
  - One clock, clk.
  - RSTM is asynchronous and active-high. It clears all M-register state immediately, with no clock edge required.
- Partial-product split:
  - M1 = A_mult (signed) × {1'b0, B_mult[8:0]} (unsigned low 9 bits), sign-extended to 43 bits.
  - M2 = (A_mult (signed) × B_mult[17:9] (signed 9-bit)) << 9, truncated to 43 bits.
  - M1 + M2 mod 2^43 equals the exact signed product A_mult × B_mult. This is the verification invariant.
- Sign flag:
  - mult_sign = A_mult[24] ^ B_mult[17].
  - A zero operand does not clear it; the flag is raw operand-sign XOR.
- sel_M_p = 1 (registered path):
  - M1, M2 and mult_sign are captured on the rising clk edge when CEM = 1.
  - CEM = 0 holds all three values.
  - Latency is 1 cycle from operand to output.
  - Reset values: M1 = 0, M2 = 0, mult_sign = 0.
  - RSTM has priority over CEM. Deasserting RSTM takes effect at the next enabled edge.
- sel_M_p = 0 (combinational path):
  - Outputs follow the inputs in the same cycle. Latency is 0.
  - CEM and RSTM have no effect on the outputs.
- use_mult_p = "NONE":
  - M1, M2 and mult_sign are constant 0 regardless of inputs, CEM, RSTM or sel_M_p.
  - Register contents are also held at 0.
- Width rules:
  - All internal products are computed at 43 bits, with no overflow possible: |A×B| ≤ 2^41.
  - The extreme case A = −2^24, B = −2^17 gives +2^41 and must be exact.
- Simultaneous events:
  - RSTM asserted on the same edge as CEM = 1 gives outputs 0.
  - RSTM deasserted mid-stream: the first capture occurs at the first enabled edge after release.
- Any unrecognised use_mult_p string behaves as "MULTIPLY".

Test Plan:
1. sel_M_p=1, CEM=1, A=3, B=5, one edge → M1=15, M2=0, mult_sign=0. Before the edge, outputs are still at reset 0.
2. A=25'h1FFFFFF (−1), B=18'h3FFFF (−1), registered → M1=43'h7FFFFFFFE01 (−511), M2=512, M1+M2=1, mult_sign=0.
3. A=25'h1000000 (−2^24), B=18'h20000 (−2^17) → M1=0, M2=43'h20000000000 (2^41), mult_sign=0. Then A=100, B=−3 → sum mod 2^43 = −300, mult_sign=1.
4. Load A=7, B=9 (M1=63). Set CEM=0 and change inputs to A=2, B=2 for 3 cycles → outputs hold 63/0. Then pulse RSTM between clock edges → M1, M2 and mult_sign go to 0 immediately, without a clock edge.
5. sel_M_p=0: apply A=−10, B=1000 → M1+M2 = −10000 in the same cycle, mult_sign=1. Toggling RSTM or CEM leaves the outputs unchanged.
6. use_mult_p="NONE": random A/B with CEM=1 for 20 cycles → M1=M2=0 and mult_sign=0 throughout.

Source files
------------

// File: rtl/mult_25x18_mreg_if.sv
// Operand and partial-product bundle between the pre-adder/B stages,
// the 25x18 multiplier and the ALU stage.
interface mult_25x18_mreg_if;
  logic        CEM;
  logic [24:0] A_mult;
  logic [17:0] B_mult;
  logic [42:0] M1;
  logic [42:0] M2;
  logic        mult_sign;

  modport master (
    output CEM,
    output A_mult,
    output B_mult,
    input  M1,
    input  M2,
    input  mult_sign
  );

  modport slave (
    input  CEM,
    input  A_mult,
    input  B_mult,
    output M1,
    output M2,
    output mult_sign
  );
endinterface

// File: rtl/mult_25x18_mreg.sv
// 25x18 signed multiplier split into two 43-bit partial products
// plus product-sign flag, with an optional M pipeline register.
module mult_25x18_mreg #(
  parameter int    sel_M_p    = 1,
  parameter string use_mult_p = "MULTIPLY"
) (
  input logic              clk,
  input logic              RSTM,
  mult_25x18_mreg_if.slave m_if
);

  localparam bit mult_en = (use_mult_p != "NONE");
  localparam bit reg_en  = (sel_M_p != 0);

  logic signed [42:0] a_ext;
  logic signed [42:0] b_lo;
  logic signed [42:0] b_hi;
  logic signed [42:0] p_lo;
  logic signed [42:0] p_hi;

  logic [42:0] m1_d;
  logic [42:0] m2_d;
  logic        s_d;

  logic [42:0] m1_q;
  logic [42:0] m2_q;
  logic        s_q;

  // Low 9 bits of B are an unsigned digit; the high 9 bits carry the sign.
  always_comb begin
    a_ext = {{18{m_if.A_mult[24]}}, m_if.A_mult};
    b_lo  = {34'd0, m_if.B_mult[8:0]};
    b_hi  = {{34{m_if.B_mult[17]}}, m_if.B_mult[17:9]};
    p_lo  = a_ext * b_lo;
    p_hi  = a_ext * b_hi;
  end

  always_comb begin
    m1_d = '0;
    m2_d = '0;
    s_d  = 1'b0;
    if (mult_en) begin
      m1_d = p_lo;
      m2_d = p_hi << 9;
      s_d  = m_if.A_mult[24] ^ m_if.B_mult[17];
    end
  end

  always_ff @(posedge clk or posedge RSTM) begin
    if (RSTM) begin
      m1_q <= '0;
      m2_q <= '0;
      s_q  <= 1'b0;
    end else if (!mult_en) begin
      m1_q <= '0;
      m2_q <= '0;
      s_q  <= 1'b0;
    end else if (m_if.CEM) begin
      m1_q <= m1_d;
      m2_q <= m2_d;
      s_q  <= s_d;
    end
  end

  always_comb begin
    m_if.M1        = '0;
    m_if.M2        = '0;
    m_if.mult_sign = 1'b0;
    if (mult_en) begin
      m_if.M1        = reg_en ? m1_q : m1_d;
      m_if.M2        = reg_en ? m2_q : m2_d;
      m_if.mult_sign = reg_en ? s_q  : s_d;
    end
  end

endmodule
